// File: rtl/mem_bus_pkg.sv
// Shared definitions for the processor memory bus: funct3 access codes,
// responder FSM states, request opcodes and the access legality check.
package mem_bus_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {OP_LOAD, OP_STORE} op_t;

   // High when the access type is undefined or the address is not naturally aligned.
   function automatic logic access_err(input logic [2:0] f3, input logic [1:0] lo);
      logic bad;
      case (f3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = lo[0];
         F3_W:        bad = (lo != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Core-to-memory request/response bundle. The core drives the request side
// (master); the memory responder answers with data, stall and error (slave).
interface data_memory_responder_if;
   logic        mem_load;
   logic        mem_store;
   logic [2:0]  mem_type;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [31:0] mem_out;
   logic        mem_stall;
   logic        mem_err;

   modport master (
      output mem_load, mem_store, mem_type, mem_addr, mem_data,
      input  mem_out, mem_stall, mem_err
   );

   modport slave (
      input  mem_load, mem_store, mem_type, mem_addr, mem_data,
      output mem_out, mem_stall, mem_err
   );
endinterface

// File: rtl/ram_word_be.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. Contents survive reset.
module ram_word_be #(
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = "",
   localparam int   AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          rd_en,
   input  logic          wr_en,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/data_memory_responder.sv
// Memory responder for the multicycle core: latches a request, reads the word,
// then either merges a partial store or formats the load result.
//
// state  | meaning
// IDLE   | waiting for a request; issues the RAM read when one appears
// ACCESS | read data back; store commits or load result is registered
// DONE   | result valid, stall low while the request is held unchanged
module data_memory_responder
   import mem_bus_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = ""
) (
   input  logic                   clk,
   input  logic                   rst_n,
   data_memory_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t      state;
   op_t         lat_op;
   logic [31:0] lat_addr;
   logic [31:0] lat_data;
   logic [2:0]  lat_type;
   logic [31:0] out_q;
   logic        err_q;

   logic          req;
   op_t           req_op;
   logic          match;
   logic          acc_err;
   logic          ram_rd;
   logic          ram_wr;
   logic [AW-1:0] ram_addr;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;

   assign req    = bus.mem_load | bus.mem_store;
   assign req_op = bus.mem_store ? OP_STORE : OP_LOAD;
   assign match  = (req_op == lat_op) && (bus.mem_addr == lat_addr) &&
                   (bus.mem_type == lat_type);

   assign bus.mem_stall = rst_n && req && !((state == DONE) && match);
   assign bus.mem_out   = out_q;
   assign bus.mem_err   = err_q;

   assign acc_err = access_err(lat_type, lat_addr[1:0]);

   // Read is issued from the live address in IDLE; every later cycle works on the latch.
   assign ram_rd   = (state == IDLE) && req;
   assign ram_wr   = (state == ACCESS) && (lat_op == OP_STORE) && !acc_err;
   assign ram_addr = (state == IDLE) ? bus.mem_addr[AW+1:2] : lat_addr[AW+1:2];

   always_comb begin
      be    = 4'b1111;
      wdata = lat_data;
      case (lat_type[1:0])
         2'b00: begin
            be    = 4'b0001 << lat_addr[1:0];
            wdata = {4{lat_data[7:0]}};
         end
         2'b01: begin
            be    = lat_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{lat_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = lat_data;
         end
      endcase
   end

   always_comb begin
      byte_sel = rdata[7:0];
      case (lat_addr[1:0])
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = lat_addr[1] ? rdata[31:16] : rdata[15:0];
      case (lat_type)
         F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_val = {24'd0, byte_sel};
         F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_val = {16'd0, half_sel};
         default: load_val = rdata;
      endcase
   end

   ram_word_be #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INIT_FILE   (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .rd_en (ram_rd),
      .wr_en (ram_wr),
      .be    (be),
      .wdata (wdata),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lat_op   <= OP_LOAD;
         lat_addr <= '0;
         lat_data <= '0;
         lat_type <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_op   <= req_op;
                  lat_addr <= bus.mem_addr;
                  lat_data <= bus.mem_data;
                  lat_type <= bus.mem_type;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (acc_err) begin
                  out_q <= '0;
                  err_q <= 1'b1;
               end else if (lat_op == OP_LOAD) begin
                  out_q <= load_val;
                  err_q <= 1'b0;
               end else begin
                  err_q <= 1'b0;
               end
               state <= DONE;
            end
            DONE: begin
               if (!req || !match) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a byte-addressed reference memory
// predicts every response; a negedge monitor compares each completed request.
module tb_data_memory_responder;
   import mem_bus_pkg::*;

   typedef struct {
      logic [31:0] out;
      logic        err;
      int          stalls;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_memory_responder_if bus();

   data_memory_responder #(
      .DEPTH_WORDS (1024),
      .INIT_FILE   ("")
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        sb[$];
   logic [7:0]  ref_mem [4096];
   logic [31:0] last_out = '0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          stall_cnt = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Little-endian byte memory of 4 KiB; addresses wrap modulo its size.
   function automatic exp_t model(logic st, logic [2:0] f3, logic [31:0] addr,
                                  logic [31:0] data, int stalls);
      exp_t        e;
      int          size;
      int          a;
      logic        bad;
      logic [31:0] v;
      a    = int'(addr[11:0]);
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      bad  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || ((a % size) != 0);
      if (bad) begin
         last_out = '0;
      end else if (st) begin
         for (int i = 0; i < size; i++) ref_mem[a + i] = data[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + i];
         if (f3 == F3_B) v = {{24{v[7]}}, v[7:0]};
         if (f3 == F3_H) v = {{16{v[15]}}, v[15:0]};
         last_out = v;
      end
      e.out    = last_out;
      e.err    = bad;
      e.stalls = stalls;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stall_cnt = 0;
      end else if (bus.mem_stall) begin
         stall_cnt++;
      end else if ((bus.mem_load || bus.mem_store) && stall_cnt > 0) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_completion: got out=%h with no pending request", bus.mem_out);
         end else begin
            e = sb.pop_front();
            check("mem_out", bus.mem_out, e.out);
            check("mem_err", {31'd0, bus.mem_err}, {31'd0, e.err});
            check("stall_cycles", stall_cnt, e.stalls);
         end
         stall_cnt = 0;
      end
   end

   task automatic issue(input logic st, input logic ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int stalls, input bit drop);
      bit done;
      @(posedge clk);
      #1;
      bus.mem_store = st;
      bus.mem_load  = ld;
      bus.mem_type  = f3;
      bus.mem_addr  = addr;
      bus.mem_data  = data;
      sb.push_back(model(st, f3, addr, data, stalls));
      done = 1'b0;
      for (int i = 0; i < 12 && !done; i++) begin
         @(negedge clk);
         if (!bus.mem_stall) done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL completion_timeout: stall still %b after 12 cycles, required 0", bus.mem_stall);
      end
      if (drop) begin
         @(posedge clk);
         #1;
         bus.mem_load  = 1'b0;
         bus.mem_store = 1'b0;
      end
   endtask

   initial begin
      logic [2:0] f3;
      logic       st;
      bus.mem_load  = 1'b0;
      bus.mem_store = 1'b0;
      bus.mem_type  = 3'b000;
      bus.mem_addr  = '0;
      bus.mem_data  = '0;

      #1 bus.mem_load = 1'b1;
      #2;
      check("reset_stall", {31'd0, bus.mem_stall}, 32'd0);
      check("reset_out", bus.mem_out, 32'd0);
      check("reset_err", {31'd0, bus.mem_err}, 32'd0);
      bus.mem_load = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;

      issue(1, 0, F3_W, 32'h100, 32'hDEADBEEF, 2, 1);
      issue(0, 1, F3_W, 32'h100, 32'h0, 2, 1);
      issue(0, 1, F3_B, 32'h103, 32'h0, 2, 1);
      issue(0, 1, F3_BU, 32'h103, 32'h0, 2, 1);
      issue(0, 1, F3_H, 32'h102, 32'h0, 2, 1);
      issue(0, 1, F3_HU, 32'h100, 32'h0, 2, 1);
      issue(1, 0, F3_B, 32'h101, 32'h12345677, 2, 1);
      issue(0, 1, F3_W, 32'h100, 32'h0, 2, 1);
      issue(1, 0, F3_H, 32'h102, 32'hAAAA1234, 2, 1);
      issue(0, 1, F3_W, 32'h100, 32'h0, 2, 1);

      issue(0, 1, F3_W, 32'h102, 32'h0, 2, 1);
      issue(1, 0, F3_H, 32'h101, 32'h0000FFFF, 2, 1);
      issue(0, 1, F3_W, 32'h100, 32'h0, 2, 1);
      issue(0, 1, 3'b011, 32'h100, 32'h0, 2, 1);

      // Held request in DONE, then an address switch without dropping the request.
      issue(1, 0, F3_W, 32'h104, 32'hCAFEF00D, 2, 1);
      issue(0, 1, F3_W, 32'h100, 32'h0, 2, 0);
      @(posedge clk);
      issue(0, 1, F3_W, 32'h104, 32'h0, 3, 1);
      issue(1, 1, F3_W, 32'h108, 32'h01020304, 2, 1);
      issue(0, 1, F3_W, 32'h108, 32'h0, 2, 1);

      // Reset during ACCESS of a store: the write must be dropped.
      issue(1, 0, F3_W, 32'h200, 32'h11223344, 2, 1);
      @(posedge clk);
      #1;
      bus.mem_store = 1'b1;
      bus.mem_type  = F3_W;
      bus.mem_addr  = 32'h200;
      bus.mem_data  = 32'h55;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_stall", {31'd0, bus.mem_stall}, 32'd0);
      check("midreset_out", bus.mem_out, 32'd0);
      check("midreset_err", {31'd0, bus.mem_err}, 32'd0);
      bus.mem_store = 1'b0;
      last_out = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      issue(0, 1, F3_W, 32'h200, 32'h0, 2, 1);

      issue(1, 0, F3_W, 32'h0, 32'h0BADF00D, 2, 1);
      issue(0, 1, F3_W, 32'h1000, 32'h0, 2, 1);
      issue(1, 0, F3_W, 32'h1004, 32'h00000077, 2, 1);
      issue(0, 1, F3_W, 32'h4, 32'h0, 2, 1);

      for (int w = 0; w < 16; w++) issue(1, 0, F3_W, 32'h100 + 32'(4 * w), $urandom, 2, 1);
      for (int n = 0; n < 60; n++) begin
         st = ($urandom_range(0, 2) == 0);
         f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         issue(st, !st, f3, 32'h100 + 32'($urandom_range(0, 63)), $urandom, 2, 1);
      end

      repeat (3) @(posedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
